echo_assertion_bank: RTL and testbench
======================================

ECHO_ASSERTION_BANK -- requirements
Module: echo_assertion_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent echo channels (1..32).
REQ-002 Parameter CNT_W, default 4, width of each channel's latency counter (2..16).
REQ-003 Parameter IMMEDIATE, default 1, 1 = assertion also high in the trigger cycle itself.
REQ-004 Parameter RETRIGGER, default 1, 1 = trigger during an active echo reloads the counter; 0 = such a trigger is ignored.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 trigger  in  CHANNELS  per-channel start request, bit i = channel i.
REQ-008 latency  in  CHANNELS*CNT_W  per-channel echo length; channel i uses bits [i*CNT_W +: CNT_W]; sampled only on an accepted trigger.
REQ-009 cancel  in  CHANNELS  per-channel abort.
REQ-010 assertion  out  CHANNELS  per-channel echoed assertion.
REQ-011 expire  out  CHANNELS  per-channel last-cycle indicator.
REQ-012 any_assertion  out  1  OR of all assertion bits.
REQ-013 active_count  out  $clog2(CHANNELS+1)  number of set assertion bits.

Function
REQ-014 Each channel i SHALL own one CNT_W-bit down-counter cnt[i]; channels SHALL NOT interact except through any_assertion/active_count.
REQ-015 Accepted trigger: trigger[i]=1, cancel[i]=0, and (cnt[i]==0 or RETRIGGER=1).
REQ-016 Next-state priority per channel: cancel[i] -> cnt 0; else accepted trigger -> cnt = latency[i]; else cnt!=0 -> cnt-1; else hold 0.
REQ-017 Counter SHALL never wrap: decrement only when nonzero.
REQ-018 assertion[i] = ~cancel[i] & ((cnt[i]!=0) | (IMMEDIATE & trigger[i])), combinational.
REQ-019 With IMMEDIATE=1 an accepted trigger with latency L SHALL give assertion high for exactly 1+L consecutive cycles (trigger cycle plus L); with IMMEDIATE=0, L cycles starting the cycle after trigger.
REQ-020 latency[i]=0 on an accepted trigger SHALL load 0: only the immediate cycle (if IMMEDIATE) asserts; with RETRIGGER=1 this truncates an active echo.
REQ-021 RETRIGGER=0, trigger while cnt[i]!=0: trigger ignored, counter keeps decrementing; with IMMEDIATE=1 assertion already high, no visible change.
REQ-022 expire[i] = (cnt[i]==1) & ~cancel[i] & ~accepted trigger; combinational, high exactly in the final cycle of a naturally ending echo.
REQ-023 A zero-latency echo SHALL produce no expire pulse.
REQ-024 cancel[i] SHALL drop assertion[i] and expire[i] in the same cycle and clear the counter on the next edge; simultaneous trigger and cancel: cancel wins, trigger lost.
REQ-025 any_assertion and active_count SHALL be combinational from assertion; active_count = popcount, range 0..CHANNELS.
REQ-026 All outputs purely function of cnt and current inputs; no further internal state.

Reset
REQ-027 rst=1 SHALL clear all cnt[i] to 0 immediately, regardless of clk.
REQ-028 While rst=1: assertion, expire, any_assertion, active_count SHALL be 0 even if trigger is high (IMMEDIATE path masked by rst).
REQ-029 Reset mid-echo: echo terminates without expire pulse; first accepted trigger after rst release behaves as from idle.

Verification (CHANNELS=4, CNT_W=4, IMMEDIATE=1, RETRIGGER=1 unless stated)
REQ-030 trigger[0] one cycle at T, latency[0]=3 -> assertion[0] high T..T+3 (4 cycles), expire[0] high only at T+3, active_count=1 throughout.
REQ-031 trigger[1] latency 5 at T, again latency 2 at T+2 -> assertion[1] high T..T+4, expire[1] at T+4; repeat with RETRIGGER=0 -> high T..T+5, expire at T+5.
REQ-032 trigger[2] latency 15 at T, cancel[2] at T+4 -> assertion[2] high T..T+3, low from T+4, no expire; trigger+cancel same cycle -> no assertion.
REQ-033 triggers on all 4 channels same cycle, latencies 1,2,3,4 -> active_count 4,4,3,2,1,0 on successive cycles; any_assertion falls after 5th cycle.
REQ-034 latency[3]=0 trigger -> single-cycle assertion[3], no expire; IMMEDIATE=0 build -> no assertion at all.
REQ-035 rst asserted asynchronously (between edges) during a latency-10 echo -> assertion drops before next edge, no expire; after release trigger latency 2 -> 3-cycle echo.

Source files
------------

// File: rtl/echo_assertion_bank_if.sv
// Bundle of per-channel echo requests and the resulting assertion/expire status.
interface echo_assertion_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 4
);
    localparam int unsigned ACT_W = $clog2(CHANNELS + 1);

    logic [CHANNELS-1:0]       trigger;
    logic [CHANNELS*CNT_W-1:0] latency;
    logic [CHANNELS-1:0]       cancel;
    logic [CHANNELS-1:0]       assertion;
    logic [CHANNELS-1:0]       expire;
    logic                      any_assertion;
    logic [ACT_W-1:0]          active_count;

    modport master (
        output trigger, latency, cancel,
        input  assertion, expire, any_assertion, active_count
    );

    modport slave (
        input  trigger, latency, cancel,
        output assertion, expire, any_assertion, active_count
    );
endinterface

// File: rtl/echo_assertion_bank.sv
// Bank of independent down-counters that stretch a trigger into a fixed-length
// assertion, with per-channel cancel and an end-of-echo pulse.
module echo_assertion_bank #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned IMMEDIATE = 1,
    parameter int unsigned RETRIGGER = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    echo_assertion_bank_if.slave bus
);
    localparam int unsigned ACT_W  = $clog2(CHANNELS + 1);
    localparam bit          IMM_EN = (IMMEDIATE != 0);
    localparam bit          RT_EN  = (RETRIGGER != 0);

    logic [CNT_W-1:0]    cnt     [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] asrt;
    logic [CHANNELS-1:0] expr;
    logic [ACT_W-1:0]    act_sum;

    // Per-channel accept decision, next count and status; rst masks the immediate path.
    always_comb begin
        accept = '0;
        asrt   = '0;
        expr   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            accept[i] = bus.trigger[i] & ~bus.cancel[i] & ((cnt[i] == '0) | RT_EN);
            if (bus.cancel[i]) begin
                cnt_nxt[i] = '0;
            end else if (accept[i]) begin
                cnt_nxt[i] = bus.latency[i*CNT_W +: CNT_W];
            end else if (cnt[i] != '0) begin
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
            asrt[i] = ~rst & ~bus.cancel[i] & ((cnt[i] != '0) | (IMM_EN & bus.trigger[i]));
            expr[i] = ~rst & ~bus.cancel[i] & ~accept[i] & (cnt[i] == CNT_W'(1));
        end
    end

    always_comb begin
        act_sum = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            act_sum = act_sum + ACT_W'(asrt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bus.assertion     = asrt;
    assign bus.expire        = expr;
    assign bus.any_assertion = |asrt;
    assign bus.active_count  = act_sum;
endmodule

// File: tb/tb_echo_assertion_bank.sv
// Scoreboard bench for echo_assertion_bank: three builds (default, no retrigger,
// no immediate) share stimulus; a per-cycle reference model feeds an expected queue.
module tb_echo_assertion_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;

    echo_assertion_bank_if #(.CHANNELS(4), .CNT_W(4)) bus0 ();
    echo_assertion_bank_if #(.CHANNELS(4), .CNT_W(4)) bus1 ();
    echo_assertion_bank_if #(.CHANNELS(4), .CNT_W(4)) bus2 ();

    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(1), .RETRIGGER(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(1), .RETRIGGER(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    echo_assertion_bank #(.CHANNELS(4), .CNT_W(4), .IMMEDIATE(0), .RETRIGGER(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // {assertion[3:0], expire[3:0], any_assertion, active_count[2:0]}
    logic [11:0] got [3];
    assign got[0] = {bus0.assertion, bus0.expire, bus0.any_assertion, bus0.active_count};
    assign got[1] = {bus1.assertion, bus1.expire, bus1.any_assertion, bus1.active_count};
    assign got[2] = {bus2.assertion, bus2.expire, bus2.any_assertion, bus2.active_count};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [11:0] sb [$];

    int rem    [3][4];
    int hi_cnt [3][4];
    int ex_cnt [3][4];
    int imm_cfg [3] = '{1, 1, 0};
    int rt_cfg  [3] = '{1, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] lat4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic clear_counts();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 4; i++) begin
                hi_cnt[c][i] = 0;
                ex_cnt[c][i] = 0;
            end
    endtask

    // One clock cycle: drive at negedge, predict, sample 1 time unit later, then advance model.
    task automatic step(input logic r, input logic [3:0] tr, input logic [15:0] lt, input logic [3:0] cn);
        int nxt [3][4];
        logic [3:0]  ea, ee;
        logic [11:0] want;
        int act;
        @(negedge clk);
        rst = r;
        bus0.trigger = tr; bus0.latency = lt; bus0.cancel = cn;
        bus1.trigger = tr; bus1.latency = lt; bus1.cancel = cn;
        bus2.trigger = tr; bus2.latency = lt; bus2.cancel = cn;
        for (int c = 0; c < 3; c++) begin
            ea  = '0;
            ee  = '0;
            act = 0;
            for (int i = 0; i < 4; i++) begin
                bit acc;
                int l;
                if (r) rem[c][i] = 0;
                l   = int'(lt[i*4 +: 4]);
                acc = tr[i] && !cn[i] && (rem[c][i] == 0 || rt_cfg[c] == 1);
                ea[i] = !r && !cn[i] && (rem[c][i] > 0 || (imm_cfg[c] == 1 && tr[i]));
                ee[i] = !r && !cn[i] && !acc && rem[c][i] == 1;
                if (ea[i]) act++;
                if (r || cn[i])        nxt[c][i] = 0;
                else if (acc)          nxt[c][i] = l;
                else if (rem[c][i] > 0) nxt[c][i] = rem[c][i] - 1;
                else                   nxt[c][i] = 0;
            end
            want = {ea, ee, |ea, 3'(act)};
            sb.push_back(want);
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("dut%0d_cyc%0d", c, cyc), 32'(got[c]), 32'(sb.pop_front()));
            for (int i = 0; i < 4; i++) begin
                if (got[c][8+i]) hi_cnt[c][i]++;
                if (got[c][4+i]) ex_cnt[c][i]++;
                rem[c][i] = nxt[c][i];
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 16'h0, 4'h0);
    endtask

    int ac_seq [6] = '{4, 4, 3, 2, 1, 0};

    initial begin
        bus0.trigger = '0; bus0.latency = '0; bus0.cancel = '0;
        bus1.trigger = '0; bus1.latency = '0; bus1.cancel = '0;
        bus2.trigger = '0; bus2.latency = '0; bus2.cancel = '0;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 4; i++) rem[c][i] = 0;

        // Reset with triggers high: outputs masked.
        step(1'b1, 4'hF, lat4(3, 3, 3, 3), 4'h0);
        check("rst_masked", 32'(got[0]), 32'h0);
        step(1'b1, 4'h0, 16'h0, 4'h0);
        idle(1);

        // Single echo, latency 3.
        clear_counts();
        step(1'b0, 4'b0001, lat4(3, 0, 0, 0), 4'h0);
        idle(5);
        check("l3_len", 32'(hi_cnt[0][0]), 32'd4);
        check("l3_expire", 32'(ex_cnt[0][0]), 32'd1);

        // Retrigger at T+2 with shorter latency.
        clear_counts();
        step(1'b0, 4'b0010, lat4(0, 5, 0, 0), 4'h0);
        idle(1);
        step(1'b0, 4'b0010, lat4(0, 2, 0, 0), 4'h0);
        idle(6);
        check("rt_len", 32'(hi_cnt[0][1]), 32'd5);
        check("nort_len", 32'(hi_cnt[1][1]), 32'd6);
        check("nort_expire", 32'(ex_cnt[1][1]), 32'd1);
        check("noimm_rt_len", 32'(hi_cnt[2][1]), 32'd4);

        // Cancel mid-echo, then trigger+cancel together.
        clear_counts();
        step(1'b0, 4'b0100, lat4(0, 0, 15, 0), 4'h0);
        idle(3);
        step(1'b0, 4'h0, 16'h0, 4'b0100);
        idle(3);
        check("cancel_len", 32'(hi_cnt[0][2]), 32'd4);
        check("cancel_noexp", 32'(ex_cnt[0][2]), 32'd0);
        clear_counts();
        step(1'b0, 4'b0100, lat4(0, 0, 7, 0), 4'b0100);
        idle(2);
        check("trig_cancel", 32'(hi_cnt[0][2]), 32'd0);

        // All channels at once, latencies 1..4.
        step(1'b0, 4'hF, lat4(1, 2, 3, 4), 4'h0);
        check("all_ac0", 32'(got[0][2:0]), 32'(ac_seq[0]));
        for (int k = 1; k < 6; k++) begin
            idle(1);
            check($sformatf("all_ac%0d", k), 32'(got[0][2:0]), 32'(ac_seq[k]));
        end
        check("all_any_off", 32'(got[0][3]), 32'd0);

        // Zero latency.
        clear_counts();
        step(1'b0, 4'b1000, lat4(0, 0, 0, 0), 4'h0);
        idle(2);
        check("l0_len", 32'(hi_cnt[0][3]), 32'd1);
        check("l0_noexp", 32'(ex_cnt[0][3]), 32'd0);
        check("l0_noimm", 32'(hi_cnt[2][3]), 32'd0);

        // Reset mid-echo, then a fresh short echo.
        clear_counts();
        step(1'b0, 4'b0001, lat4(10, 0, 0, 0), 4'h0);
        idle(3);
        step(1'b1, 4'h0, 16'h0, 4'h0);
        check("rst_drop", 32'(got[0]), 32'h0);
        check("rst_noexp", 32'(ex_cnt[0][0]), 32'd0);
        idle(1);
        clear_counts();
        step(1'b0, 4'b0001, lat4(2, 0, 0, 0), 4'h0);
        idle(4);
        check("post_rst_len", 32'(hi_cnt[0][0]), 32'd3);
        check("post_rst_exp", 32'(ex_cnt[0][0]), 32'd1);

        // Random traffic against the model.
        for (int k = 0; k < 60; k++) begin
            logic [3:0]  tr, cn;
            logic [15:0] lt;
            tr = 4'($urandom) & 4'($urandom);
            cn = 4'($urandom) & 4'($urandom) & 4'($urandom);
            lt = 16'($urandom);
            step(1'b0, tr, lt, cn);
        end
        idle(16);

        if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
